// File: rtl/cpu_test_pkg.sv
// cpu_test_pkg: shared FSM encoding and saturating-counter helpers used by
// the CPU run monitor and its statistics counters.
package cpu_test_pkg;

    // Monitor FSM encoding (kept as plain constants for legacy compatibility).
    localparam int unsigned        STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_HOLD = 2'd1;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

    // Widest counter the saturating helpers support.
    localparam int unsigned SAT_MAX_W = 64;

    // All-ones value of a counter 'width' bits wide, held in a 64-bit container.
    function automatic logic [SAT_MAX_W-1:0] sat_limit(input int unsigned width);
        if (width >= SAT_MAX_W) begin
            return '1;
        end
        return (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
    endfunction

    // Next value of a saturating counter: sticks at all-ones, otherwise +1.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                     input int unsigned           width);
        if (value >= sat_limit(width)) begin
            return sat_limit(width);
        end
        return value + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/cpu_run_monitor_sat_counter.sv
// sat_counter: up-counter with enable and synchronous clear that saturates
// at all-ones instead of wrapping. WIDTH may be at most SAT_MAX_W bits.
module sat_counter
    import cpu_test_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Clear wins over enable; the increment rule comes from the shared package.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= WIDTH'(sat_inc(SAT_MAX_W'(count), WIDTH));
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: holds a CPU under test in reset for a fixed number of
// cycles, then watches its retirement stream until it halts (same PC retired
// repeatedly) or the cycle budget runs out, and reports pass/timeout plus
// cycle, instruction and taken-branch statistics.
module cpu_run_monitor
    import cpu_test_pkg::*;
#(
    parameter int unsigned         PC_WIDTH     = 32,
    parameter int unsigned         CNT_WIDTH    = 32,
    parameter int unsigned         RESET_CYCLES = 4,
    parameter int unsigned         MAX_CYCLES   = 500,
    parameter int unsigned         HALT_REPEAT  = 3,
    parameter logic [PC_WIDTH-1:0] EXPECT_PC    = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 pc_valid,
    input  logic                 branch_taken,
    output logic                 cpu_rst_n,
    output logic                 running,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [PC_WIDTH-1:0]  halt_pc
);

    // Hold counter only needs to reach RESET_CYCLES-1, repeat counter HALT_REPEAT-1.
    localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned REP_W  = (HALT_REPEAT > 1) ? $clog2(HALT_REPEAT) : 1;

    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [REP_W-1:0]     REP_LAST  = REP_W'(HALT_REPEAT - 1);
    // Compared at full width so a narrow cycle counter cannot alias the budget.
    localparam logic [SAT_MAX_W-1:0] CYC_LAST  = SAT_MAX_W'(MAX_CYCLES) - SAT_MAX_W'(1);

    logic [STATE_W-1:0]  state;
    logic [STATE_W-1:0]  state_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [REP_W-1:0]    rep_cnt;
    logic [REP_W-1:0]    rep_nxt;
    logic [PC_WIDTH-1:0] last_pc;
    logic [PC_WIDTH-1:0] last_nxt;
    logic                seeded;
    logic                seeded_nxt;
    logic                in_run;
    logic                launch;
    logic                retire;
    logic                branch_hit;
    logic                halt_hit;
    logic                time_hit;

    assign in_run     = (state == ST_RUN);
    assign running    = in_run;
    assign done       = (state == ST_DONE);
    // start is only honoured from IDLE or DONE; it clears all run results.
    assign launch     = start && ((state == ST_IDLE) || (state == ST_DONE));
    // Retirement inputs are meaningful only while the CPU is running.
    assign retire     = in_run && pc_valid;
    assign branch_hit = retire && branch_taken;
    // This RUN cycle is the one that brings cycle_count up to the budget.
    // A counter that saturates below the budget never times out.
    assign time_hit   = in_run && (SAT_MAX_W'(cycle_count) == CYC_LAST);

    // Halt detection: count valid retirements that repeat the previous valid PC.
    always_comb begin
        rep_nxt    = rep_cnt;
        last_nxt   = last_pc;
        seeded_nxt = seeded;
        halt_hit   = 1'b0;
        if (retire) begin
            if (!seeded) begin
                // First retirement of a run only establishes the reference PC.
                seeded_nxt = 1'b1;
                last_nxt   = pc;
            end else if (pc == last_pc) begin
                if (rep_cnt == REP_LAST) begin
                    halt_hit = 1'b1;
                end else begin
                    rep_nxt = rep_cnt + REP_W'(1);
                end
            end else begin
                rep_nxt  = '0;
                last_nxt = pc;
            end
        end
    end

    // Next-state logic; a halt and a timeout on the same cycle both end the run.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_hit || time_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt = ST_HOLD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counts the cycles already spent in HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (launch) begin
            hold_cnt <= '0;
        end else if ((state == ST_HOLD) && (hold_cnt != HOLD_LAST)) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    // Halt-tracking registers, restarted at the beginning of every run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_cnt <= '0;
            last_pc <= '0;
            seeded  <= 1'b0;
        end else if (launch) begin
            rep_cnt <= '0;
            last_pc <= '0;
            seeded  <= 1'b0;
        end else begin
            rep_cnt <= rep_nxt;
            last_pc <= last_nxt;
            seeded  <= seeded_nxt;
        end
    end

    // Run verdict, latched on the cycle the run ends; halt takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halt_pc <= '0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else if (launch) begin
            halt_pc <= '0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else if (halt_hit) begin
            halt_pc <= pc;
            pass    <= (pc == EXPECT_PC);
            timeout <= 1'b0;
        end else if (time_hit) begin
            pass    <= 1'b0;
            timeout <= 1'b1;
        end
    end

    // CPU reset is registered from the next state so it is low exactly in HOLD
    // and also low while the monitor itself is in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_rst_n <= 1'b0;
        end else begin
            cpu_rst_n <= (state_nxt != ST_HOLD);
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (launch),
        .en    (in_run),
        .count (cycle_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (launch),
        .en    (retire),
        .count (instr_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (launch),
        .en    (branch_hit),
        .count (branch_count)
    );

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: randomized scenario bench for cpu_run_monitor with a
// high-level model (run-length of equal valid PCs, min() saturation).
`timescale 1ns/1ps
module tb_cpu_run_monitor;

    localparam int          RC     = 4;
    localparam int          MAXC   = 500;
    localparam int          HREP   = 3;
    localparam logic [31:0] EXP_PC = 32'h8;
    localparam int          S_RC   = 2;
    localparam int          S_MAXC = 100;
    localparam logic [31:0] S_EXP  = 32'h40;
    localparam int          NSTIM  = 600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pc = '0;
    logic        pc_valid = 1'b0;
    logic        branch_taken = 1'b0;
    logic        cpu_rst_n, running, done, pass, timeout;
    logic [31:0] cycle_count, instr_count, branch_count, halt_pc;

    logic        s_start = 1'b0;
    logic [31:0] s_pc = '0;
    logic        s_pc_valid = 1'b0;
    logic        s_branch_taken = 1'b0;
    logic        s_cpu_rst_n, s_running, s_done, s_pass, s_timeout;
    logic [3:0]  s_cyc, s_ins, s_brc;
    logic [31:0] s_hpc;

    int total = 0;
    int bad = 0;

    bit          sv [NSTIM];
    logic [31:0] sp [NSTIM];
    bit          sb [NSTIM];

    bit          m_halt;
    logic [31:0] m_hpc;
    int          m_cyc, m_ins, m_br;

    always #1 clk = ~clk;

    cpu_run_monitor #(
        .PC_WIDTH(32), .CNT_WIDTH(32), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC),
        .HALT_REPEAT(HREP), .EXPECT_PC(EXP_PC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .pc_valid(pc_valid),
        .branch_taken(branch_taken), .cpu_rst_n(cpu_rst_n), .running(running),
        .done(done), .pass(pass), .timeout(timeout), .cycle_count(cycle_count),
        .instr_count(instr_count), .branch_count(branch_count), .halt_pc(halt_pc)
    );

    cpu_run_monitor #(
        .PC_WIDTH(32), .CNT_WIDTH(4), .RESET_CYCLES(S_RC), .MAX_CYCLES(S_MAXC),
        .HALT_REPEAT(HREP), .EXPECT_PC(S_EXP)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .pc(s_pc), .pc_valid(s_pc_valid),
        .branch_taken(s_branch_taken), .cpu_rst_n(s_cpu_rst_n), .running(s_running),
        .done(s_done), .pass(s_pass), .timeout(s_timeout), .cycle_count(s_cyc),
        .instr_count(s_ins), .branch_count(s_brc), .halt_pc(s_hpc)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic clear_stim();
        for (int i = 0; i < NSTIM; i++) begin
            sv[i] = 1'b0;
            sp[i] = '0;
            sb[i] = 1'b0;
        end
    endtask

    // Reference: the run ends at the first valid retirement that completes a run
    // of hrep+1 equal consecutive valid PCs, or at RUN cycle maxc-1.
    task automatic model(input int maxc, input int hrep, input int sat);
        int          run_len;
        int          last_i;
        logic [31:0] prev;
        bit          have;
        run_len = 0;
        last_i  = maxc - 1;
        prev    = '0;
        have    = 1'b0;
        m_halt  = 1'b0;
        m_hpc   = '0;
        m_ins   = 0;
        m_br    = 0;
        for (int i = 0; i < maxc; i++) begin
            if (sv[i]) begin
                m_ins++;
                if (sb[i]) m_br++;
                run_len = (have && sp[i] == prev) ? run_len + 1 : 1;
                prev = sp[i];
                have = 1'b1;
                if (run_len == hrep + 1) begin
                    m_halt = 1'b1;
                    m_hpc  = sp[i];
                end
            end
            if (m_halt) begin
                last_i = i;
                break;
            end
        end
        m_cyc = last_i + 1;
        if (sat != 0) begin
            if (m_cyc > sat) m_cyc = sat;
            if (m_ins > sat) m_ins = sat;
            if (m_br > sat)  m_br  = sat;
        end
    endtask

    // Drive one complete run of the main instance from the stimulus arrays.
    task automatic run_main(input string tag, input int hold_checks);
        int          low;
        int          n;
        bit          e_pass;
        logic [31:0] e_hpc;
        model(MAXC, HREP, 0);
        e_pass = m_halt && (m_hpc == EXP_PC);
        e_hpc  = m_halt ? m_hpc : '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        total++;
        if (done !== 1'b0 || cycle_count !== 0 || instr_count !== 0 || branch_count !== 0 ||
            pass !== 1'b0 || timeout !== 1'b0 || halt_pc !== 0) begin
            bad++;
            $display("FAIL %s clear_on_start: done=%0d cyc=%0d ins=%0d br=%0d pass=%0d to=%0d hpc=%0h, want all 0",
                     tag, done, cycle_count, instr_count, branch_count, pass, timeout, halt_pc);
        end
        low = 0;
        for (int k = 0; k < 20 && running !== 1'b1; k++) begin
            if (cpu_rst_n === 1'b0) low++;
            start        = (k == 1);
            pc           = $urandom;
            pc_valid     = 1'b1;
            branch_taken = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (low !== RC || running !== 1'b1 || cpu_rst_n !== 1'b1) begin
            bad++;
            $display("FAIL %s hold: low_cycles=%0d running=%0d cpu_rst_n=%0d, want %0d 1 1",
                     tag, low, running, cpu_rst_n, RC);
        end
        total++;
        if (cycle_count !== 0 || instr_count !== 0 || branch_count !== 0) begin
            bad++;
            $display("FAIL %s hold_ignore: cyc=%0d ins=%0d br=%0d, want 0 0 0",
                     tag, cycle_count, instr_count, branch_count);
        end
        n = 0;
        while (done !== 1'b1 && n < 700) begin
            if (n < NSTIM) begin
                pc_valid = sv[n]; pc = sp[n]; branch_taken = sb[n];
            end else begin
                pc_valid = 1'b0; pc = '0; branch_taken = 1'b0;
            end
            start = (n == 37);
            n++;
            @(negedge clk);
        end
        start = 1'b0; pc_valid = 1'b0; branch_taken = 1'b0;
        total++;
        if (done !== 1'b1 || running !== 1'b0 || cpu_rst_n !== 1'b1) begin
            bad++;
            $display("FAIL %s end: done=%0d running=%0d cpu_rst_n=%0d, want 1 0 1",
                     tag, done, running, cpu_rst_n);
        end
        total++;
        if (cycle_count !== 32'(m_cyc) || instr_count !== 32'(m_ins) || branch_count !== 32'(m_br)) begin
            bad++;
            $display("FAIL %s counts: cyc=%0d ins=%0d br=%0d, want %0d %0d %0d",
                     tag, cycle_count, instr_count, branch_count, m_cyc, m_ins, m_br);
        end
        total++;
        if (halt_pc !== e_hpc || pass !== e_pass || timeout !== !m_halt) begin
            bad++;
            $display("FAIL %s verdict: hpc=%0h pass=%0d to=%0d, want %0h %0d %0d",
                     tag, halt_pc, pass, timeout, e_hpc, e_pass, !m_halt);
        end
        for (int k = 0; k < hold_checks; k++) begin
            pc = $urandom; pc_valid = 1'($urandom); branch_taken = 1'($urandom);
            @(negedge clk);
            total++;
            if (done !== 1'b1 || running !== 1'b0 || cycle_count !== 32'(m_cyc) ||
                instr_count !== 32'(m_ins) || branch_count !== 32'(m_br) ||
                halt_pc !== e_hpc || pass !== e_pass) begin
                bad++;
                $display("FAIL %s done_hold: done=%0d cyc=%0d ins=%0d br=%0d hpc=%0h pass=%0d, want 1 %0d %0d %0d %0h %0d",
                         tag, done, cycle_count, instr_count, branch_count, halt_pc, pass,
                         m_cyc, m_ins, m_br, e_hpc, e_pass);
            end
        end
        pc_valid = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (cpu_rst_n !== 1'b0 || running !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
            timeout !== 1'b0 || cycle_count !== 0 || instr_count !== 0 ||
            branch_count !== 0 || halt_pc !== 0) begin
            bad++;
            $display("FAIL reset_state: cpu_rst_n=%0d run=%0d done=%0d pass=%0d to=%0d cyc=%0d ins=%0d br=%0d hpc=%0h, want all 0",
                     cpu_rst_n, running, done, pass, timeout, cycle_count, instr_count, branch_count, halt_pc);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (cpu_rst_n !== 1'b1 || running !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: cpu_rst_n=%0d run=%0d done=%0d, want 1 0 0",
                     cpu_rst_n, running, done);
        end
    endtask

    task automatic test_halt_pass();
        logic [31:0] seq [6];
        seq = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8};
        clear_stim();
        for (int i = 0; i < 6; i++) begin
            sv[i] = 1'b1; sp[i] = seq[i];
        end
        run_main("halt_pass", 4);
        total++;
        if (pass !== 1'b1 || halt_pc !== 32'h8 || instr_count !== 6 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL halt_pass_fixed: pass=%0d hpc=%0h ins=%0d to=%0d, want 1 8 6 0",
                     pass, halt_pc, instr_count, timeout);
        end
    endtask

    task automatic test_branches();
        clear_stim();
        sv[0] = 1; sp[0] = 32'h100; sb[0] = 1;
        sv[1] = 1; sp[1] = 32'h104;
        sv[2] = 0; sp[2] = 32'h999; sb[2] = 1;
        sv[3] = 1; sp[3] = 32'h108; sb[3] = 1;
        sv[4] = 1; sp[4] = 32'h10c;
        sv[5] = 1; sp[5] = 32'h110;
        sv[6] = 0; sp[6] = 32'h200; sb[6] = 1;
        sv[7] = 1; sp[7] = 32'h114; sb[7] = 1;
        for (int i = 8; i < 12; i++) begin
            sv[i] = 1; sp[i] = 32'h200;
        end
        run_main("branches", 2);
        total++;
        if (branch_count !== 3 || instr_count !== 10 || halt_pc !== 32'h200 || pass !== 1'b0) begin
            bad++;
            $display("FAIL branches_fixed: br=%0d ins=%0d hpc=%0h pass=%0d, want 3 10 200 0",
                     branch_count, instr_count, halt_pc, pass);
        end
    endtask

    task automatic test_timeout();
        clear_stim();
        for (int i = 0; i < NSTIM; i++) begin
            sv[i] = ($urandom_range(0, 3) != 0);
            sp[i] = 32'h1000 + 32'(4 * i);
            sb[i] = 1'($urandom);
        end
        run_main("timeout", 3);
        total++;
        if (cycle_count !== 32'(MAXC) || timeout !== 1'b1 || pass !== 1'b0) begin
            bad++;
            $display("FAIL timeout_fixed: cyc=%0d to=%0d pass=%0d, want %0d 1 0",
                     cycle_count, timeout, pass, MAXC);
        end
    endtask

    task automatic test_coincide(input logic [31:0] hpc);
        clear_stim();
        for (int i = 0; i < MAXC - 4; i++) begin
            sv[i] = 1'b1; sp[i] = 32'h1000 + 32'(4 * i); sb[i] = 1'($urandom);
        end
        for (int i = MAXC - 4; i < MAXC; i++) begin
            sv[i] = 1'b1; sp[i] = hpc;
        end
        run_main("coincide", 0);
        total++;
        if (timeout !== 1'b0 || pass !== (hpc == EXP_PC) || cycle_count !== 32'(MAXC) || halt_pc !== hpc) begin
            bad++;
            $display("FAIL coincide_fixed: to=%0d pass=%0d cyc=%0d hpc=%0h, want 0 %0d %0d %0h",
                     timeout, pass, cycle_count, halt_pc, (hpc == EXP_PC), MAXC, hpc);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            clear_stim();
            for (int i = 0; i < NSTIM; i++) begin
                sv[i] = ($urandom_range(0, 3) != 0);
                sp[i] = 32'(4 * $urandom_range(0, 3));
                sb[i] = 1'($urandom);
            end
            run_main("random", 1);
        end
    endtask

    task automatic test_midrun_reset();
        int stray;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 20 && running !== 1'b1; k++) @(negedge clk);
        for (int k = 0; k < 30; k++) begin
            pc_valid = 1'b1; pc = 32'h2000 + 32'(4 * k); branch_taken = 1'b1;
            @(negedge clk);
        end
        total++;
        if (running !== 1'b1 || cycle_count !== 30 || instr_count !== 30) begin
            bad++;
            $display("FAIL midrun_pre: run=%0d cyc=%0d ins=%0d, want 1 30 30",
                     running, cycle_count, instr_count);
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (running !== 1'b0 || done !== 1'b0 || cpu_rst_n !== 1'b0 || cycle_count !== 0 ||
            instr_count !== 0 || branch_count !== 0) begin
            bad++;
            $display("FAIL midrun_reset: run=%0d done=%0d cpu_rst_n=%0d cyc=%0d ins=%0d br=%0d, want 0 0 0 0 0 0",
                     running, done, cpu_rst_n, cycle_count, instr_count, branch_count);
        end
        rst_n = 1'b1; pc_valid = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        total++;
        if (cpu_rst_n !== 1'b1 || running !== 1'b0) begin
            bad++;
            $display("FAIL midrun_release: cpu_rst_n=%0d run=%0d, want 1 0", cpu_rst_n, running);
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        total++;
        if (cpu_rst_n !== 1'b0) begin
            bad++;
            $display("FAIL midhold_pre: cpu_rst_n=%0d, want 0", cpu_rst_n);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cpu_rst_n !== 1'b1 || running !== 1'b0 || done !== 1'b0) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("FAIL midhold_reset: cycles_not_idle=%0d, want 0", stray);
        end
    endtask

    task automatic test_saturation();
        int low;
        int n;
        clear_stim();
        for (int i = 0; i < 20; i++) begin
            sv[i] = 1'b1; sp[i] = 32'h1000 + 32'(4 * i); sb[i] = 1'b1;
        end
        for (int i = 20; i < 24; i++) begin
            sv[i] = 1'b1; sp[i] = S_EXP; sb[i] = 1'b1;
        end
        model(S_MAXC, HREP, 15);
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        low = 0;
        for (int k = 0; k < 20 && s_running !== 1'b1; k++) begin
            if (s_cpu_rst_n === 1'b0) low++;
            @(negedge clk);
        end
        total++;
        if (low !== S_RC || s_running !== 1'b1) begin
            bad++;
            $display("FAIL sat_hold: low_cycles=%0d run=%0d, want %0d 1", low, s_running, S_RC);
        end
        n = 0;
        while (s_done !== 1'b1 && n < 200) begin
            if (n < NSTIM) begin
                s_pc_valid = sv[n]; s_pc = sp[n]; s_branch_taken = sb[n];
            end else begin
                s_pc_valid = 1'b0; s_branch_taken = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        s_pc_valid = 1'b0; s_branch_taken = 1'b0;
        total++;
        if (s_done !== 1'b1 || s_cyc !== 4'(m_cyc) || s_ins !== 4'(m_ins) || s_brc !== 4'(m_br)) begin
            bad++;
            $display("FAIL sat_counts: done=%0d cyc=%0d ins=%0d br=%0d, want 1 %0d %0d %0d",
                     s_done, s_cyc, s_ins, s_brc, m_cyc, m_ins, m_br);
        end
        total++;
        if (s_hpc !== S_EXP || s_pass !== 1'b1 || s_timeout !== 1'b0) begin
            bad++;
            $display("FAIL sat_verdict: hpc=%0h pass=%0d to=%0d, want %0h 1 0",
                     s_hpc, s_pass, s_timeout, S_EXP);
        end
    endtask

    initial begin
        test_reset();
        test_halt_pass();
        test_branches();
        test_timeout();
        test_coincide(EXP_PC);
        test_coincide(32'h44);
        test_random();
        test_midrun_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_monitor.md
CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

Interface
REQ-001 Parameter PC_WIDTH, default 32: width of the program-counter input.
REQ-002 Parameter CNT_WIDTH, default 32: width of the cycle, instruction and branch counters.
REQ-003 Parameter RESET_CYCLES, default 4: number of cycles cpu_rst_n is held low after start.
REQ-004 Parameter MAX_CYCLES, default 500: run-cycle budget before timeout; 500 cycles equals 1000 ns at a 2 ns clock.
REQ-005 Parameter HALT_REPEAT, default 3: consecutive valid retirements at an unchanged PC that declare a halt.
REQ-006 Parameter EXPECT_PC, default 0: halt PC required for pass.
REQ-007 clk  in  1  single clock; all state updates on the rising edge.
REQ-008 rst_n  in  1  synchronous, active-low reset.
REQ-009 start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
REQ-010 pc  in  PC_WIDTH  PC of the retiring instruction.
REQ-011 pc_valid  in  1  an instruction retires this cycle.
REQ-012 branch_taken  in  1  the retiring instruction is a taken branch; qualified by pc_valid.
REQ-013 cpu_rst_n  out  1  active-low reset driven to the CPU under test.
REQ-014 running  out  1  high in RUN state.
REQ-015 done  out  1  high in DONE state.
REQ-016 pass  out  1  valid while done is high.
REQ-017 timeout  out  1  valid while done is high.
REQ-018 cycle_count  out  CNT_WIDTH  RUN cycles elapsed.
REQ-019 instr_count  out  CNT_WIDTH  retirements counted.
REQ-020 branch_count  out  CNT_WIDTH  taken branches counted.
REQ-021 halt_pc  out  PC_WIDTH  PC at which the halt was detected.

Function
REQ-022 FSM states SHALL be IDLE, HOLD, RUN and DONE.
REQ-023 IDLE->HOLD on start; on entry, clear all counters, halt_pc, pass and timeout.
REQ-024 HOLD SHALL drive cpu_rst_n=0 for exactly RESET_CYCLES cycles, then go to RUN; cpu_rst_n=1 in every other state.
REQ-025 In RUN, cycle_count SHALL increment every cycle.
REQ-026 In RUN, instr_count SHALL increment on each cycle with pc_valid=1.
REQ-027 In RUN, branch_count SHALL increment on each cycle with pc_valid=1 and branch_taken=1.
REQ-028 Counters SHALL saturate at all-ones and never wrap.
REQ-029 Halt detect: a repeat counter SHALL increment when pc_valid=1 and pc equals the last valid PC, and reset to 0 on any valid PC change; pc_valid=0 cycles SHALL leave it unchanged.
REQ-030 When the repeat count reaches HALT_REPEAT: RUN->DONE, latch halt_pc, set pass=(pc==EXPECT_PC), set timeout=0.
REQ-031 When cycle_count reaches MAX_CYCLES without a halt: RUN->DONE with timeout=1, pass=0.
REQ-032 If halt and timeout occur in the same cycle, halt SHALL win.
REQ-033 The first valid PC in a run SHALL only seed the last-PC register and SHALL NOT count as a repeat.
REQ-034 DONE SHALL hold all outputs stable until start, which re-enters HOLD.
REQ-035 start SHALL be ignored in HOLD and RUN.
REQ-036 pc_valid and branch_taken SHALL be ignored outside RUN.

Reset
REQ-037 rst_n=0 at a rising edge SHALL return the block to IDLE from any state, including mid-HOLD or mid-RUN.
REQ-038 While rst_n=0: all counters=0, halt_pc=0, pass=0, timeout=0, running=0, done=0, cpu_rst_n=0.
REQ-039 cpu_rst_n SHALL rise to 1 on the first cycle after rst_n is released.

Structure
REQ-040 The FSM state encoding and the saturating-increment width rule SHALL live in the shared package cpu_test_pkg.
REQ-041 One sub-module, sat_counter (parametrised width, enable, synchronous clear), SHALL be instantiated three times.

Verification
REQ-042 Reset then start, RESET_CYCLES=4 -> cpu_rst_n low for exactly 4 cycles, then running=1.
REQ-043 PC stream 0,4,8,8,8,8 all valid, EXPECT_PC=8 -> done, pass=1, halt_pc=8, instr_count=6.
REQ-044 No halt, MAX_CYCLES=500 -> done at cycle_count=500 with timeout=1 and pass=0.
REQ-045 10 valid retirements, 3 of them with branch_taken, plus 2 branch_taken cycles with pc_valid=0 -> branch_count=3.
REQ-046 rst_n asserted mid-RUN -> next cycle state is IDLE, counters=0, cpu_rst_n=0.
REQ-047 Halt reached on the same cycle as MAX_CYCLES -> pass per EXPECT_PC, timeout=0.
